psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum.sv | 158 +++++++++++++++
 tb/tb_psum_accum.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum.sv
// psum_accum: gathers partial sums from the bottom of a PE column over
// num_passes passes of num_rows rows, then drains one accumulated result
// per row through a valid/ready output port.
module psum_accum #(
  parameter int PSUM_W = 48,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] num_rows,
  input  logic [7:0]             num_passes,
  input  logic                   psum_valid,
  input  logic [PSUM_W-1:0]      psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PSUM_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       rows_q;
  logic [7:0]          passes_q;
  logic [IW-1:0]       row_idx;
  logic [7:0]          pass_idx;
  logic [IW-1:0]       rd_idx;

  logic [PSUM_W-1:0]   entry [DEPTH];

  logic                start_ok;
  logic                wr_en;
  logic [PSUM_W-1:0]   rd_word;
  logic [PSUM_W:0]     sum_ext;
  logic [PSUM_W-1:0]   wr_data;
  logic                last_row;
  logic                last_pass;
  logic [IW-1:0]       nxt_rd;
  logic                nxt_rd_last;

  assign busy = (state != IDLE);

  // Datapath decode: start qualification, accumulate add and index compares.
  // NOTE: every signal assigned here gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    start_ok    = start && (num_rows != '0) && (num_rows <= CW'(DEPTH)) &&
                  (num_passes != 8'd0);
    wr_en       = !rst && (state == ACCUM) && psum_valid;
    rd_word     = entry[row_idx];
    sum_ext     = {1'b0, rd_word} + {1'b0, psum_in};
    // The first pass overwrites, so stale contents from an earlier job never leak in.
    wr_data     = (pass_idx == 8'd0) ? psum_in : sum_ext[PSUM_W-1:0];
    last_row    = ({1'b0, row_idx} == (rows_q - CW'(1)));
    last_pass   = (pass_idx == (passes_q - 8'd1));
    nxt_rd      = rd_idx + IW'(1);
    nxt_rd_last = ({1'b0, nxt_rd} == (rows_q - CW'(1)));
  end

  // Accumulator storage: written once per valid partial sum in ACCUM.
  // NOTE: the buffer has no reset on purpose; pass 0 always overwrites, so
  // clearing it would only cost a reset net on every storage bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry[row_idx] <= wr_data;
    end
  end

  // Control FSM with registered drain outputs, done pulse and sticky overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      passes_q  <= '0;
      row_idx   <= '0;
      pass_idx  <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= ACCUM;
            rows_q   <= num_rows;
            passes_q <= num_passes;
            row_idx  <= '0;
            pass_idx <= '0;
            rd_idx   <= '0;
            overflow <= 1'b0;
          end
        end

        ACCUM: begin
          if (psum_valid) begin
            if ((pass_idx != 8'd0) && sum_ext[PSUM_W]) begin
              overflow <= 1'b1;
            end
            if (last_row) begin
              row_idx  <= '0;
              pass_idx <= pass_idx + 8'd1;
              if (last_pass) begin
                state     <= DRAIN;
                pass_idx  <= '0;
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_last  <= (rows_q == CW'(1));
                // Row 0 is being written this very cycle only for one-row jobs.
                out_data  <= (row_idx == '0) ? wr_data : entry[0];
              end
            end else begin
              row_idx <= row_idx + IW'(1);
            end
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              rd_idx   <= nxt_rd;
              out_data <= entry[nxt_rd];
              out_last <= nxt_rd_last;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every output transfer.
module tb_psum_accum;

  localparam int PSUM_W = 48;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        num_rows;
  logic [7:0]        num_passes;
  logic              psum_valid;
  logic [PSUM_W-1:0] psum_in;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              overflow;

  psum_accum #(.PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rows   (num_rows),
    .num_passes (num_passes),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PSUM_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output beat is compared with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h, expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int rows, input int passes);
    start      = 1'b1;
    num_rows   = 5'(rows);
    num_passes = 8'(passes);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [PSUM_W-1:0] v);
    psum_valid = 1'b1;
    psum_in    = v;
    tick();
  endtask

  task automatic push(input logic [PSUM_W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the done pulse and checks the done cycle itself.
  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_done_busy"}, 64'(busy), 64'd0);
      check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
    end
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0;
    int gaps [12] = '{0, 1, 3, 0, 2, 0, 0, 5, 1, 0, 4, 2};
    int bad_rows [3] = '{0, DEPTH + 1, 4};
    int bad_pass [3] = '{1, 1, 0};

    rst        = 1'b1;
    start      = 1'b0;
    num_rows   = '0;
    num_passes = '0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic: 4 rows x 3 passes of row+1 -> 3,6,9,12
    start_job(4, 3);
    @(negedge clk);
    check("basic_busy",      64'(busy),      64'd1);
    check("basic_acc_valid", 64'(out_valid), 64'd0);
    check("basic_acc_data",  64'(out_data),  64'd0);
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 4; r++) feed(PSUM_W'(r + 1));
    psum_valid = 1'b0;
    push(48'd3, 1'b0);
    push(48'd6, 1'b0);
    push(48'd9, 1'b0);
    push(48'd12, 1'b1);
    @(negedge clk);
    check("basic_first_valid", 64'(out_valid), 64'd1);
    tick();
    out_ready = 1'b1;
    wait_done("basic");
    check("basic_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    tick();

    // Backpressure: stall 5 cycles at rd_idx=1
    start_job(4, 3);
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 4; r++) feed(PSUM_W'(r + 1));
    psum_valid = 1'b0;
    push(48'd3, 1'b0);
    push(48'd6, 1'b0);
    push(48'd9, 1'b0);
    push(48'd12, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data",  64'(out_data),  64'd6);
      check("bp_hold_last",  64'(out_last),  64'd0);
    end
    tick();
    out_ready = 1'b1;
    wait_done("bp");
    out_ready = 1'b0;
    tick();

    // Overflow/wrap: (2^48-1) + 2 -> 1 with overflow set
    start_job(1, 2);
    feed({PSUM_W{1'b1}});
    feed(48'd2);
    psum_valid = 1'b0;
    push(48'd1, 1'b1);
    @(negedge clk);
    check("ovf_flag", 64'(overflow), 64'd1);
    tick();
    out_ready = 1'b1;
    wait_done("ovf");
    out_ready = 1'b0;
    check("ovf_sticky", 64'(overflow), 64'd1);
    tick();

    // Illegal starts: rows=0, rows=DEPTH+1, passes=0 -> stay IDLE
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      start_job(bad_rows[i], bad_pass[i]);
      @(negedge clk);
      check("illegal_busy", 64'(busy), 64'd0);
      check("illegal_ovf_kept", 64'(overflow), 64'd1);
      tick();
    end
    check("illegal_no_done", 64'(done_cnt), 64'(d0));

    // Stale data, job A: DEPTH rows x 2 passes of 1000+r -> 2000+2r
    start_job(DEPTH, 2);
    @(negedge clk);
    check("start_clears_ovf", 64'(overflow), 64'd0);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < DEPTH; r++) feed(PSUM_W'(1000 + r));
    psum_valid = 1'b0;
    for (int r = 0; r < DEPTH; r++) push(PSUM_W'(2000 + 2 * r), r == DEPTH - 1);
    out_ready = 1'b1;
    wait_done("stale_a");
    out_ready = 1'b0;
    tick();

    // Stale data, job B: DEPTH rows x 2 passes of 7(r+1) -> 14(r+1)
    start_job(DEPTH, 2);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < DEPTH; r++) feed(PSUM_W'(7 * (r + 1)));
    psum_valid = 1'b0;
    for (int r = 0; r < DEPTH; r++) push(PSUM_W'(14 * (r + 1)), r == DEPTH - 1);
    out_ready = 1'b1;
    wait_done("stale_b");
    out_ready = 1'b0;
    tick();

    // Gaps and ignored start/psum_valid: same results as the basic job
    start_job(4, 3);
    for (int k = 0; k < 12; k++) begin
      psum_valid = 1'b0;
      if (k == 5) begin
        start      = 1'b1;
        num_rows   = 5'd2;
        num_passes = 8'd1;
      end
      for (int g = 0; g < gaps[k]; g++) tick();
      start = 1'b0;
      feed(PSUM_W'((k % 4) + 1));
    end
    psum_in    = 48'hDEAD;
    push(48'd3, 1'b0);
    push(48'd6, 1'b0);
    push(48'd9, 1'b0);
    push(48'd12, 1'b1);
    start      = 1'b1;
    num_rows   = 5'd1;
    num_passes = 8'd1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("gap_drain_hold", 64'(out_data), 64'd3);
    tick();
    out_ready = 1'b1;
    wait_done("gaps");
    psum_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    @(negedge clk);
    check("gap_no_new_job", 64'(busy), 64'd0);
    tick();

    // Reset mid-DRAIN: aborts with no done pulse
    start_job(2, 1);
    feed(48'd5);
    feed(48'd7);
    psum_valid = 1'b0;
    @(negedge clk);
    check("rd_in_drain", 64'(out_valid), 64'd1);
    d0 = done_cnt;
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rd_busy",  64'(busy),      64'd0);
    check("rd_valid", 64'(out_valid), 64'd0);
    check("rd_done",  64'(done),      64'd0);
    repeat (3) @(negedge clk);
    check("rd_no_done", 64'(done_cnt), 64'(d0));
    check("rd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
